manch_en: RTL and testbench

//  Manchester transmitter on the 16x line clock. Accepts one byte per valid/ready handshake and drives it onto the

---
 rtl/manch_pkg.sv | 26 ++
 rtl/manch_bit_timer.sv | 46 ++++
 rtl/manch_en.sv | 150 +++++++++++++++
 tb/tb_manch_en.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/manch_pkg.sv
// ----------------------------------------------------------------------------
// manch_pkg : state encoding, line constants and half-bit helper for the link
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package manch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } manch_tx_state_e;

  localparam logic MANCH_IDLE_LEVEL = 1'b1;
  localparam logic MANCH_START_BIT  = 1'b0;

  function automatic logic manch_half(input int unsigned cnt, input int unsigned oversample);
    return cnt >= (oversample / 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/manch_bit_timer.sv
// ----------------------------------------------------------------------------
// manch_bit_timer : bit-period counter producing the bit-end strobe and the
//                   half-bit level that applies after the next clock edge
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module manch_bit_timer
  import manch_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk16x,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic bit_end,
  output logic half_nxt
);

  localparam int CNT_W = $clog2(OVERSAMPLE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    bit_end = run && (cnt_q == CNT_W'(OVERSAMPLE - 1));
    cnt_d   = cnt_q + CNT_W'(1);
    if (!run || restart || bit_end) begin
      cnt_d = '0;
    end
    // The owner registers mdo from next-cycle values, so it needs next half.
    half_nxt = manch_half(32'(cnt_d), 32'(OVERSAMPLE));
  end

  always_ff @(posedge clk16x) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/manch_en.sv
// ----------------------------------------------------------------------------
// manch_en : Manchester byte transmitter (start, data MSB-first, [parity], gap)
//            Optional parity bit enabled by defining MANCH_EN_PARITY_EN.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module manch_en
  import manch_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int IDLE_BITS  = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk16x,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              mdo,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(IDLE_BITS + 1);

  manch_tx_state_e   state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0]  gap_idx_q, gap_idx_d;
  logic              mdo_q, mdo_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_done_q, tx_done_d;

  logic xfer;
  logic bit_end;
  logic half_nxt;
  logic par_bit;

  assign din_ready = (state_q == IDLE) && !rst;
  assign xfer      = din_valid && din_ready;
  assign mdo       = mdo_q;
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;

  manch_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_timer (
    .clk16x   (clk16x),
    .rst      (rst),
    .run      (state_q != IDLE),
    .restart  (xfer),
    .bit_end  (bit_end),
    .half_nxt (half_nxt)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    bit_idx_d = bit_idx_q;
    gap_idx_d = gap_idx_q;
    tx_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d   = START;
          shreg_d   = din;
          par_d     = 1'b0;
          bit_idx_d = '0;
          gap_idx_d = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          par_d   = par_q ^ shreg_q[DATA_W-1];
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
            bit_idx_d = '0;
`ifdef MANCH_EN_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = GAP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = GAP;
      end
      GAP: begin
        if (bit_end) begin
          if (gap_idx_q == GAP_W'(IDLE_BITS - 1)) begin
            gap_idx_d = '0;
            state_d   = IDLE;
            tx_done_d = 1'b1;
          end else begin
            gap_idx_d = gap_idx_q + GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_busy_d = (state_d != IDLE);
    par_bit   = par_d ^ (PARITY_ODD != 0);

    // Output level for the cycle after this edge, from the state being entered.
    case (state_d)
      START:   mdo_d = MANCH_START_BIT ^ half_nxt;
      DATA:    mdo_d = shreg_d[DATA_W-1] ^ half_nxt;
      PARITY:  mdo_d = par_bit ^ half_nxt;
      default: mdo_d = MANCH_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk16x) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      bit_idx_q <= '0;
      gap_idx_q <= '0;
      mdo_q     <= MANCH_IDLE_LEVEL;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      bit_idx_q <= bit_idx_d;
      gap_idx_q <= gap_idx_d;
      mdo_q     <= mdo_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_manch_en.sv
// ----------------------------------------------------------------------------
// tb_manch_en : self-checking bench for manch_en (line-level model + literals)
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_manch_en;

  localparam int DATA_W     = 8;
  localparam int OVERSAMPLE = 16;
  localparam int IDLE_BITS  = 2;
  localparam int PARITY_ODD = 0;
  localparam int HALF       = OVERSAMPLE / 2;
`ifdef MANCH_EN_PARITY_EN
  localparam int NHALVES = 20;
  localparam int DONE_AT = 192;
`else
  localparam int NHALVES = 18;
  localparam int DONE_AT = 176;
`endif

  logic              clk16x = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic              mdo;
  logic              tx_busy;
  logic              tx_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic              rst_s = 1'b1;
  logic              valid_s = 1'b0;
  logic [DATA_W-1:0] din_s = '0;

  logic lvl_q[$];
  logic exp_mdo  = 1'b1;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;

  manch_en #(
    .DATA_W     (DATA_W),
    .OVERSAMPLE (OVERSAMPLE),
    .IDLE_BITS  (IDLE_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk16x    (clk16x),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .mdo       (mdo),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk16x = ~clk16x;

  // Inputs as seen by each rising edge, consumed by the model at the next falling edge.
  always @(posedge clk16x) begin
    cyc     <= cyc + 1;
    rst_s   <= rst;
    valid_s <= din_valid;
    din_s   <= din;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Line model: a frame is a list of bits, each drawn as level then inverted level.
  task automatic push_frame(input logic [DATA_W-1:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = DATA_W - 1; i >= 0; i--) bits.push_back(b[i]);
`ifdef MANCH_EN_PARITY_EN
    bits.push_back((^b) ^ (PARITY_ODD != 0));
`endif
    foreach (bits[i]) begin
      repeat (HALF) lvl_q.push_back(bits[i]);
      repeat (HALF) lvl_q.push_back(!bits[i]);
    end
    repeat (IDLE_BITS * OVERSAMPLE) lvl_q.push_back(1'b1);
  endtask

  initial begin
    forever begin
      @(negedge clk16x);
      if (cyc > 0) begin
        if (rst_s) begin
          lvl_q.delete();
          exp_mdo  = 1'b1;
          exp_busy = 1'b0;
          exp_done = 1'b0;
        end else begin
          if (!exp_busy && valid_s) push_frame(din_s);
          if (lvl_q.size() > 0) begin
            exp_mdo  = lvl_q.pop_front();
            exp_done = 1'b0;
            exp_busy = 1'b1;
          end else begin
            exp_done = exp_busy;
            exp_busy = 1'b0;
            exp_mdo  = 1'b1;
          end
        end
        chk("mdo", 32'(mdo), 32'(exp_mdo));
        chk("tx_busy", 32'(tx_busy), 32'(exp_busy));
        chk("tx_done", 32'(tx_done), 32'(exp_done));
        chk("din_ready", 32'(din_ready), 32'(!exp_busy && !rst));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk16x);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic send(input logic [DATA_W-1:0] b, output int e);
    din       = b;
    din_valid = 1'b1;
    tick();
    e         = cyc;
    din_valid = 1'b0;
  endtask

  // Sample the middle of each half-bit symbol against a hand-written pattern.
  task automatic check_stream(input string name, input int e, input logic [31:0] pat, input int nh);
    for (int k = 0; k < nh; k++) begin
      wait_until(e + k * HALF + 3);
      chk(name, 32'(mdo), 32'(pat[nh-1-k]));
    end
  endtask

  logic [31:0] pat_a5, pat_00, pat_ff, pat_96;
  int e1, e2, dones;

  initial begin
`ifdef MANCH_EN_PARITY_EN
    pat_a5 = {12'd0, 18'b01_10_01_10_01_01_10_01_10, (PARITY_ODD != 0) ? 2'b10 : 2'b01};
    pat_00 = {12'd0, 18'b01_01_01_01_01_01_01_01_01, 2'b01};
    pat_ff = {12'd0, 18'b01_10_10_10_10_10_10_10_10, 2'b01};
    pat_96 = {12'd0, 18'b01_10_01_01_10_01_10_10_01, 2'b01};
`else
    pat_a5 = {14'd0, 18'b01_10_01_10_01_01_10_01_10};
    pat_00 = {14'd0, 18'b01_01_01_01_01_01_01_01_01};
    pat_ff = {14'd0, 18'b01_10_10_10_10_10_10_10_10};
    pat_96 = {14'd0, 18'b01_10_01_01_10_01_10_10_01};
`endif

    // Reset release
    repeat (3) tick();
    chk("ready_in_rst", 32'(din_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(din_ready), 32'd1);
    chk("mdo_after_rst", 32'(mdo), 32'd1);
    chk("busy_after_rst", 32'(tx_busy), 32'd0);
    repeat (2) tick();

    // Single byte A5
    send(8'hA5, e1);
    chk("start_low", 32'(mdo), 32'd0);
    check_stream("a5_stream", e1, pat_a5, NHALVES);
    wait_until(e1 + DONE_AT - 1);
    chk("a5_busy_before_end", 32'(tx_busy), 32'd1);
    chk("a5_done_early", 32'(tx_done), 32'd0);
    tick();
    chk("a5_done", 32'(tx_done), 32'd1);
    chk("a5_idle", 32'(tx_busy), 32'd0);
    tick();
    chk("a5_done_one_cycle", 32'(tx_done), 32'd0);

    // Back-to-back 00 then FF with din_valid held
    din       = 8'h00;
    din_valid = 1'b1;
    tick();
    e1  = cyc;
    din = 8'hFF;
    check_stream("b2b_00_stream", e1, pat_00, NHALVES);
    wait_until(e1 + DONE_AT);
    chk("b2b_ready", 32'(din_ready), 32'd1);
    chk("b2b_gap_high", 32'(mdo), 32'd1);
    tick();
    e2        = cyc;
    din_valid = 1'b0;
    chk("b2b_second_start", 32'(mdo), 32'd0);
    chk("b2b_second_busy", 32'(tx_busy), 32'd1);
    check_stream("b2b_ff_stream", e2, pat_ff, NHALVES);
    wait_until(e2 + DONE_AT + 4);

    // Reset mid-frame
    send(8'hA5, e1);
    wait_until(e1 + 69);
    rst = 1'b1;
    tick();
    chk("abort_mdo", 32'(mdo), 32'd1);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_ready_in_rst", 32'(din_ready), 32'd0);
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    send(8'h96, e1);
    check_stream("after_abort_stream", e1, pat_96, NHALVES);
    wait_until(e1 + DONE_AT);
    chk("after_abort_done", 32'(tx_done), 32'd1);
    tick();

    // din_valid pulsed late in the frame is ignored
    send(8'hC3, e1);
    wait_until(e1 + 149);
    din       = 8'h3C;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    wait_until(e1 + DONE_AT);
    chk("ignore_idle", 32'(tx_busy), 32'd0);
    chk("ignore_done", 32'(tx_done), 32'd1);
    wait_until(e1 + DONE_AT + 14);
    chk("ignore_no_frame_busy", 32'(tx_busy), 32'd0);
    chk("ignore_no_frame_mdo", 32'(mdo), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
